// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: RAM plus switch/hex I/O register behind MAR/MDR.
// Each access waits WAIT_STATES cycles, then pulses R for one cycle.
module lc3_mem_responder #(
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] DATA_W,
    input  logic [15:0] SW,
    output logic [15:0] DATA_R,
    output logic        R,
    output logic        BUSY,
    output logic [15:0] HEX_Out
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                 state;
    logic [3:0]             count;
    logic [15:0]            addr_q;
    logic [15:0]            data_q;
    logic                   we_q;
    logic [15:0]            ram [2**ADDR_BITS];
    logic                   access;
    logic                   is_io;
    logic [ADDR_BITS-1:0]   idx;

    assign access = (state == WAIT) && (count == 4'd0);
    assign is_io  = (addr_q == IO_ADDR);
    // Upper address bits are dropped, so out-of-range addresses alias.
    assign idx    = addr_q[ADDR_BITS-1:0];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
            we_q    <= 1'b0;
            DATA_R  <= 16'h0000;
            R       <= 1'b0;
            BUSY    <= 1'b0;
            HEX_Out <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    R <= 1'b0;
                    if (MEM_REQ) begin
                        addr_q <= ADDR;
                        data_q <= DATA_W;
                        we_q   <= MEM_WE;
                        count  <= WS;
                        BUSY   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (!we_q) begin
                            DATA_R <= is_io ? SW : ram[idx];
                        end else if (is_io) begin
                            HEX_Out <= data_q;
                        end
                        R     <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    R     <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    R     <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM has no reset; a reset before the access edge drops the write.
    always_ff @(posedge Clk) begin
        if (access && we_q && !is_io) begin
            ram[idx] <= data_q;
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder with a timeline-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_lc3_mem_responder;

    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        MEM_REQ = 1'b0;
    logic        MEM_WE = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] DATA_W = 16'h0000;
    logic [15:0] SW = 16'h0000;
    logic [15:0] DATA_R;
    logic        R;
    logic        BUSY;
    logic [15:0] HEX_Out;

    int total = 0;
    int bad = 0;

    lc3_mem_responder #(
        .ADDR_BITS(8),
        .WAIT_STATES(WS),
        .IO_ADDR(16'hFFFF)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE),
        .ADDR(ADDR),
        .DATA_W(DATA_W),
        .SW(SW),
        .DATA_R(DATA_R),
        .R(R),
        .BUSY(BUSY),
        .HEX_Out(HEX_Out)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: a request seen at edge k is serviced at edge
    // k+WS+1 (R visible for that cycle) and the unit is free after k+WS+2.
    logic [15:0] m_ram [256];
    logic [15:0] m_data, m_hex;
    logic        m_act, m_r;
    logic [15:0] m_addr, m_wdata;
    logic        m_we;
    int          cyc, t_acc;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_act  = 1'b0;
            m_r    = 1'b0;
            m_data = 16'h0000;
            m_hex  = 16'h0000;
            cyc    = 0;
            t_acc  = 0;
        end else begin
            cyc++;
            if (m_act && cyc == t_acc + 1) begin
                m_act = 1'b0;
                m_r   = 1'b0;
            end else if (m_act && cyc == t_acc) begin
                if (m_addr == 16'hFFFF) begin
                    if (m_we) m_hex = m_wdata;
                    else      m_data = SW;
                end else begin
                    if (m_we) m_ram[m_addr % 256] = m_wdata;
                    else      m_data = m_ram[m_addr % 256];
                end
                m_r = 1'b1;
            end else if (!m_act && MEM_REQ) begin
                m_act   = 1'b1;
                m_addr  = ADDR;
                m_we    = MEM_WE;
                m_wdata = DATA_W;
                t_acc   = cyc + WS + 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            chk("R", {15'd0, R}, {15'd0, m_r});
            chk("BUSY", {15'd0, BUSY}, {15'd0, m_act});
            chk("DATA_R", DATA_R, m_data);
            chk("HEX_Out", HEX_Out, m_hex);
        end
    end

    task automatic access(input logic we, input logic [15:0] a,
                          input logic [15:0] d, output int lat);
        @(negedge Clk);
        MEM_REQ = 1'b1;
        MEM_WE  = we;
        ADDR    = a;
        DATA_W  = d;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!R && lat < 40);
        if (!R) begin
            total++;
            bad++;
            $display("FAIL timeout: R never seen for addr %h", a);
        end
        MEM_REQ = 1'b0;
        MEM_WE  = 1'b0;
    endtask

    initial begin
        int lat, gap, rseen;
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("rst DATA_R", DATA_R, 16'h0000);
        chk("rst HEX_Out", HEX_Out, 16'h0000);
        chk("rst R", {15'd0, R}, 16'h0000);
        chk("rst BUSY", {15'd0, BUSY}, 16'h0000);

        access(1'b1, 16'h0005, 16'hBEEF, lat);
        chk("write latency", 16'(lat), 16'd4);
        chk("write keeps DATA_R", DATA_R, 16'h0000);

        access(1'b0, 16'h0005, 16'h0000, lat);
        chk("read 0005", DATA_R, 16'hBEEF);

        access(1'b1, 16'h00FF, 16'h7777, lat);
        access(1'b1, 16'h0105, 16'h1234, lat);
        access(1'b0, 16'h0005, 16'h0000, lat);
        chk("alias 0105->0005", DATA_R, 16'h1234);

        SW = 16'h00A5;
        access(1'b0, 16'hFFFF, 16'h0000, lat);
        chk("io read SW", DATA_R, 16'h00A5);

        access(1'b1, 16'hFFFF, 16'h0042, lat);
        chk("io write HEX", HEX_Out, 16'h0042);
        chk("io write keeps DATA_R", DATA_R, 16'h00A5);
        access(1'b0, 16'h00FF, 16'h0000, lat);
        chk("ram FF untouched", DATA_R, 16'h7777);

        // Back-to-back with MEM_REQ held through DONE.
        access(1'b0, 16'h0005, 16'h0000, lat);
        MEM_REQ = 1'b1;
        ADDR    = 16'h00FF;
        @(negedge Clk);
        @(negedge Clk);
        ADDR   = 16'h0005;
        MEM_WE = 1'b1;
        DATA_W = 16'hFFFF;
        SW     = 16'hFFFF;
        gap = 2;
        while (!R && gap < 40) begin
            @(negedge Clk);
            gap++;
        end
        MEM_REQ = 1'b0;
        MEM_WE  = 1'b0;
        chk("b2b gap", 16'(gap), 16'(WS + 3));
        chk("b2b second read", DATA_R, 16'h7777);
        access(1'b0, 16'h0005, 16'h0000, lat);
        chk("b2b ignored write", DATA_R, 16'h1234);

        // Reset in the middle of a write.
        access(1'b1, 16'h0010, 16'h0001, lat);
        @(negedge Clk);
        MEM_REQ = 1'b1;
        MEM_WE  = 1'b1;
        ADDR    = 16'h0010;
        DATA_W  = 16'hDEAD;
        @(negedge Clk);
        @(negedge Clk);
        #2;
        Reset   = 1'b0;
        MEM_REQ = 1'b0;
        MEM_WE  = 1'b0;
        #1;
        chk("abort R", {15'd0, R}, 16'h0000);
        chk("abort BUSY", {15'd0, BUSY}, 16'h0000);
        chk("abort DATA_R", DATA_R, 16'h0000);
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b1;
        rseen = 0;
        repeat (6) begin
            @(negedge Clk);
            if (R) rseen++;
        end
        chk("abort no R", 16'(rseen), 16'd0);
        access(1'b0, 16'h0010, 16'h0000, lat);
        chk("abort write dropped", DATA_R, 16'h0001);
        chk("read latency", 16'(lat), 16'd4);

        repeat (2) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
